// File: rtl/bp_stream_pkg.sv
// Shared constants for the host stream router: default channel addresses,
// the default NACK word and a small index-width helper.
package bp_stream_pkg;

    localparam logic [31:0] bp_stream_nbf_addr_gp  = 32'h10;
    localparam logic [31:0] bp_stream_mmio_addr_gp = 32'h20;
    localparam logic [31:0] bp_stream_nack_data_gp = 32'hDEADBEEF;

    // Width of an index into n items; never below one bit.
    function automatic int bp_stream_idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/bp_stream_return_arb.sv
// Return-path merge: round-robin arbiter over the channel return streams
// feeding a 2-entry FIFO that drives the single host output stream.
// A NACK request (from the top-level decode) takes priority over channel
// grants and leaves the round-robin pointer untouched.
module bp_stream_return_arb
    import bp_stream_pkg::*;
#(
    parameter int num_chan_p   = 2,
    parameter int data_width_p = 32
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic [num_chan_p-1:0]              chan_v_i,
    input  logic [num_chan_p*data_width_p-1:0] chan_data_i,
    output logic [num_chan_p-1:0]              chan_yumi_o,
    input  logic                               nack_v_i,
    input  logic [data_width_p-1:0]            nack_data_i,
    output logic                               fifo_ready_o,
    output logic                               stream_v_o,
    output logic [data_width_p-1:0]            stream_data_o,
    input  logic                               stream_ready_i
);

    localparam int RrW = bp_stream_idx_width(num_chan_p);

    logic [RrW-1:0]          rr_q, rr_d;
    logic [RrW-1:0]          grant_idx;
    logic                    grant_v;
    logic                    chan_hs;
    logic                    nack_enq;
    logic                    enq, deq;
    logic                    full, empty;
    logic [data_width_p-1:0] enq_data;
    logic [data_width_p-1:0] mem_q [2];
    logic                    wr_ptr_q, wr_ptr_d;
    logic                    rd_ptr_q, rd_ptr_d;
    logic [1:0]              count_q, count_d;

    // Ready comes from the registered occupancy only: no same-cycle bypass
    // of a dequeue into a full buffer.
    assign full         = (count_q == 2'd2);
    assign empty        = (count_q == 2'd0);
    assign fifo_ready_o = ~full;

    // First valid channel at or after the round-robin pointer, wrapping.
    always_comb begin
        int idx;
        grant_v   = 1'b0;
        grant_idx = '0;
        idx       = 0;
        for (int k = 0; k < num_chan_p; k++) begin
            idx = (int'(rr_q) + k) % num_chan_p;
            if (!grant_v && chan_v_i[idx]) begin
                grant_v   = 1'b1;
                grant_idx = RrW'(idx);
            end
        end
    end

    assign chan_hs  = grant_v & ~full & ~nack_v_i & ~reset_i;
    assign nack_enq = nack_v_i & ~full;
    assign enq      = chan_hs | nack_enq;
    assign deq      = ~empty & stream_ready_i;
    assign enq_data = nack_v_i ? nack_data_i
                               : chan_data_i[int'(grant_idx)*data_width_p +: data_width_p];

    // One-hot yumi toward the granted channel only.
    always_comb begin
        chan_yumi_o = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            chan_yumi_o[i] = chan_hs && (int'(grant_idx) == i);
        end
    end

    // Next-state for pointer, FIFO pointers and occupancy.
    always_comb begin
        rr_d     = chan_hs ? RrW'((int'(grant_idx) + 1) % num_chan_p) : rr_q;
        wr_ptr_d = enq ? ~wr_ptr_q : wr_ptr_q;
        rd_ptr_d = deq ? ~rd_ptr_q : rd_ptr_q;
        count_d  = count_q + {1'b0, enq} - {1'b0, deq};
    end

    // Control state; reset empties the buffer and rewinds the pointer.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_q     <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            rr_q     <= rr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Data storage needs no reset; occupancy alone says what is valid.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= enq_data;
        end
    end

    assign stream_v_o    = ~empty;
    assign stream_data_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/bp_stream_router.sv
// Host stream router: address-decodes host writes onto num_chan_p channels,
// merges channel returns onto the host output stream and counts writes to
// unmapped addresses (saturating).
// Optional: define BP_STREAM_ROUTER_NACK_EN to answer unmapped writes with
// nack_data_p on the return stream instead of dropping them silently.
module bp_stream_router
    import bp_stream_pkg::*;
#(
    parameter int num_chan_p          = 2,
    parameter int stream_addr_width_p = 32,
    parameter int stream_data_width_p = 32,
    parameter logic [num_chan_p*stream_addr_width_p-1:0] chan_addr_p =
        {bp_stream_mmio_addr_gp, bp_stream_nbf_addr_gp},
    parameter int err_cnt_width_p     = 16,
    parameter logic [stream_data_width_p-1:0] nack_data_p = bp_stream_nack_data_gp
) (
    input  logic                                      clk_i,
    input  logic                                      reset_i,
    input  logic                                      stream_v_i,
    input  logic [stream_addr_width_p-1:0]            stream_addr_i,
    input  logic [stream_data_width_p-1:0]            stream_data_i,
    output logic                                      stream_yumi_o,
    output logic [num_chan_p-1:0]                     chan_v_o,
    output logic [stream_data_width_p-1:0]            chan_data_o,
    input  logic [num_chan_p-1:0]                     chan_ready_i,
    input  logic [num_chan_p-1:0]                     chan_v_i,
    input  logic [num_chan_p*stream_data_width_p-1:0] chan_data_i,
    output logic [num_chan_p-1:0]                     chan_yumi_o,
    output logic                                      stream_v_o,
    output logic [stream_data_width_p-1:0]            stream_data_o,
    input  logic                                      stream_ready_i,
    output logic [err_cnt_width_p-1:0]                err_count_o
);

`ifdef BP_STREAM_ROUTER_NACK_EN
    localparam bit NackEn = 1'b1;
`else
    localparam bit NackEn = 1'b0;
`endif

    logic [num_chan_p-1:0]      hit;
    logic [num_chan_p-1:0]      sel;
    logic                       mapped;
    logic                       nack_v;
    logic                       fifo_ready;
    logic                       unmapped_yumi;
    logic                       err_inc;
    logic [err_cnt_width_p-1:0] err_count_q, err_count_d;

    // Exact-match decode; lowest-indexed hit wins when addresses alias.
    always_comb begin
        logic found;
        hit   = '0;
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < num_chan_p; i++) begin
            hit[i] = (stream_addr_i == chan_addr_p[i*stream_addr_width_p +: stream_addr_width_p]);
            if (hit[i] && !found) begin
                sel[i] = 1'b1;
                found  = 1'b1;
            end
        end
    end

    assign mapped      = |hit;
    assign chan_v_o    = {num_chan_p{stream_v_i}} & sel;
    assign chan_data_o = stream_data_i;

    // Unmapped writes either drop immediately or wait for return-buffer room
    // when they must be answered with a NACK word.
    assign nack_v        = NackEn & stream_v_i & ~mapped;
    assign unmapped_yumi = NackEn ? fifo_ready : 1'b1;
    assign stream_yumi_o = stream_v_i & (mapped ? |(sel & chan_ready_i) : unmapped_yumi);
    assign err_inc       = stream_v_i & ~mapped & stream_yumi_o;

    // Saturating unmapped-write count.
    always_comb begin
        err_count_d = err_count_q;
        if (err_inc && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
        end
    end

    // Error counter register.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
        end
    end

    assign err_count_o = err_count_q;

    bp_stream_return_arb #(
        .num_chan_p   (num_chan_p),
        .data_width_p (stream_data_width_p)
    ) u_ret (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .chan_v_i       (chan_v_i),
        .chan_data_i    (chan_data_i),
        .chan_yumi_o    (chan_yumi_o),
        .nack_v_i       (nack_v),
        .nack_data_i    (nack_data_p),
        .fifo_ready_o   (fifo_ready),
        .stream_v_o     (stream_v_o),
        .stream_data_o  (stream_data_o),
        .stream_ready_i (stream_ready_i)
    );

endmodule

// File: tb/tb_bp_stream_router.sv
// Directed bench for bp_stream_router (two channels at 0x10 / 0x20).
// Extra checks run when BP_STREAM_ROUTER_NACK_EN is defined.
module tb_bp_stream_router;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stream_v_i;
    logic [31:0] stream_addr_i;
    logic [31:0] stream_data_i;
    logic        stream_yumi_o;
    logic [1:0]  chan_v_o;
    logic [31:0] chan_data_o;
    logic [1:0]  chan_ready_i;
    logic [1:0]  chan_v_i;
    logic [63:0] chan_data_i;
    logic [1:0]  chan_yumi_o;
    logic        stream_v_o;
    logic [31:0] stream_data_o;
    logic        stream_ready_i;
    logic [15:0] err_count_o;

    int n_checks = 0;
    int n_fail   = 0;

    bp_stream_router dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .stream_v_i     (stream_v_i),
        .stream_addr_i  (stream_addr_i),
        .stream_data_i  (stream_data_i),
        .stream_yumi_o  (stream_yumi_o),
        .chan_v_o       (chan_v_o),
        .chan_data_o    (chan_data_o),
        .chan_ready_i   (chan_ready_i),
        .chan_v_i       (chan_v_i),
        .chan_data_i    (chan_data_i),
        .chan_yumi_o    (chan_yumi_o),
        .stream_v_o     (stream_v_o),
        .stream_data_o  (stream_data_o),
        .stream_ready_i (stream_ready_i),
        .err_count_o    (err_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic [31:0] addr;
        logic [31:0] data;
        logic [1:0]  rdy;
        logic [1:0]  exp_cv;
        logic        exp_yumi;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after a rising edge.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [31:0] rr_word(input int j);
        return (j % 2 == 0) ? 32'h100 + 32'(j / 2) : 32'h200 + 32'(j / 2);
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 2'b01, 2'b01, 1'b1};
        tbl[1] = '{1'b1, 32'h10, 32'hA5A5_0002, 2'b10, 2'b01, 1'b0};
        tbl[2] = '{1'b1, 32'h20, 32'hA5A5_0003, 2'b01, 2'b10, 1'b0};
        tbl[3] = '{1'b1, 32'h20, 32'hA5A5_0004, 2'b10, 2'b10, 1'b1};
        tbl[4] = '{1'b1, 32'h20, 32'h1234_5678, 2'b11, 2'b10, 1'b1};
        tbl[5] = '{1'b0, 32'h10, 32'h0000_0000, 2'b11, 2'b00, 1'b0};
        tbl[6] = '{1'b1, 32'h30, 32'hFFFF_0000, 2'b00, 2'b00, 1'b1};
        tbl[7] = '{1'b1, 32'h11, 32'h0F0F_0F0F, 2'b11, 2'b00, 1'b1};

        reset_i        = 1'b1;
        stream_v_i     = 1'b0;
        stream_addr_i  = '0;
        stream_data_i  = '0;
        chan_ready_i   = '0;
        chan_v_i       = 2'b11;
        chan_data_i    = '0;
        stream_ready_i = 1'b1;

        // Reset state.
        tick();
        tick();
        check("rst_stream_v", 32'(stream_v_o), 32'h0);
        check("rst_err", 32'(err_count_o), 32'h0);
        check("rst_yumi", 32'(chan_yumi_o), 32'h0);
        reset_i  = 1'b0;
        chan_v_i = 2'b00;
        tick();

        // Combinational forward path; valid drops before the next edge.
        for (int i = 0; i < 8; i++) begin
            stream_v_i    = tbl[i].v;
            stream_addr_i = tbl[i].addr;
            stream_data_i = tbl[i].data;
            chan_ready_i  = tbl[i].rdy;
            #1;
            check($sformatf("vec%0d_chan_v", i), 32'(chan_v_o), 32'(tbl[i].exp_cv));
            check($sformatf("vec%0d_yumi", i), 32'(stream_yumi_o), 32'(tbl[i].exp_yumi));
            check($sformatf("vec%0d_data", i), chan_data_o, tbl[i].data);
            stream_v_i = 1'b0;
            tick();
        end
        check("tbl_err_untouched", 32'(err_count_o), 32'h0);

        // Mapped write stalls until its channel is ready.
        stream_v_i    = 1'b1;
        stream_addr_i = 32'h20;
        stream_data_i = 32'hA5A5_0001;
        chan_ready_i  = 2'b01;
        #1;
        check("stall_yumi0", 32'(stream_yumi_o), 32'h0);
        check("stall_chan_v", 32'(chan_v_o), 32'h2);
        tick();
        check("stall_yumi1", 32'(stream_yumi_o), 32'h0);
        chan_ready_i = 2'b10;
        #1;
        check("stall_release", 32'(stream_yumi_o), 32'h1);
        tick();
        stream_v_i = 1'b0;

        // Three unmapped writes.
        stream_addr_i = 32'h30;
        for (int i = 0; i < 3; i++) begin
            stream_v_i = 1'b1;
            #1;
            check($sformatf("unmap%0d_yumi", i), 32'(stream_yumi_o), 32'h1);
            check($sformatf("unmap%0d_chan_v", i), 32'(chan_v_o), 32'h0);
            tick();
        end
        stream_v_i = 1'b0;
        #1;
        check("unmap_err3", 32'(err_count_o), 32'h3);

        // Drive the count to saturation and past it.
        stream_v_i = 1'b1;
        repeat (65531) @(posedge clk_i);
        #1;
        check("err_fffe", 32'(err_count_o), 32'hFFFE);
        tick();
        check("err_ffff", 32'(err_count_o), 32'hFFFF);
        tick();
        check("err_sat", 32'(err_count_o), 32'hFFFF);
        stream_v_i = 1'b0;
        tick();
        tick();

        // Fill the buffer with rr left at 1, then reset.
        stream_ready_i = 1'b0;
        chan_data_i    = {32'hBB, 32'hAA};
        chan_v_i       = 2'b11;
        tick();
        chan_v_i = 2'b01;
        tick();
        #1;
        check("pre_rst_full", 32'(chan_yumi_o), 32'h0);
        check("pre_rst_v", 32'(stream_v_o), 32'h1);
        reset_i  = 1'b1;
        chan_v_i = 2'b11;
        #1;
        check("in_rst_yumi", 32'(chan_yumi_o), 32'h0);
        tick();
        reset_i = 1'b0;
        check("post_rst_v", 32'(stream_v_o), 32'h0);
        check("post_rst_err", 32'(err_count_o), 32'h0);

        // Round robin from rr = 0, host always ready.
        stream_ready_i = 1'b1;
        for (int k = 0; k < 6; k++) begin
            chan_data_i = {32'h200 + 32'(k / 2), 32'h100 + 32'((k + 1) / 2)};
            #1;
            check($sformatf("rr%0d_yumi", k), 32'(chan_yumi_o), (k % 2 == 0) ? 32'h1 : 32'h2);
            if (k == 0) begin
                check("rr0_empty", 32'(stream_v_o), 32'h0);
            end else begin
                check($sformatf("rr%0d_v", k), 32'(stream_v_o), 32'h1);
                check($sformatf("rr%0d_data", k), stream_data_o, rr_word(k - 1));
            end
            tick();
        end
        chan_v_i = 2'b00;
        #1;
        check("rr_last_data", stream_data_o, rr_word(5));
        tick();
        check("rr_drained", 32'(stream_v_o), 32'h0);

        // Backpressure: two words accepted, then blocked; order preserved.
        stream_ready_i = 1'b0;
        chan_data_i    = {32'hB0, 32'hA0};
        chan_v_i       = 2'b11;
        #1;
        check("bp0_yumi", 32'(chan_yumi_o), 32'h1);
        tick();
        check("bp1_yumi", 32'(chan_yumi_o), 32'h2);
        tick();
        check("bp2_yumi", 32'(chan_yumi_o), 32'h0);
        check("bp2_data", stream_data_o, 32'hA0);
        stream_ready_i = 1'b1;
        #1;
        check("bp_full_deq_yumi", 32'(chan_yumi_o), 32'h0);
        check("bp_out0", stream_data_o, 32'hA0);
        tick();
        check("bp_resume_yumi", 32'(chan_yumi_o), 32'h1);
        check("bp_out1", stream_data_o, 32'hB0);
        tick();
        chan_v_i = 2'b00;
        #1;
        check("bp_out2", stream_data_o, 32'hA0);
        tick();
        check("bp_empty", 32'(stream_v_o), 32'h0);

`ifdef BP_STREAM_ROUTER_NACK_EN
        // Unmapped write answered with the NACK word.
        stream_v_i    = 1'b1;
        stream_addr_i = 32'h44;
        #1;
        check("nack_yumi", 32'(stream_yumi_o), 32'h1);
        tick();
        stream_v_i = 1'b0;
        check("nack_v", 32'(stream_v_o), 32'h1);
        check("nack_data", stream_data_o, 32'hDEADBEEF);
        check("nack_err1", 32'(err_count_o), 32'h1);
        tick();
        // Host stalls on unmapped writes while the buffer is full.
        stream_ready_i = 1'b0;
        stream_v_i     = 1'b1;
        tick();
        tick();
        check("nack_full_yumi", 32'(stream_yumi_o), 32'h0);
        tick();
        check("nack_err3", 32'(err_count_o), 32'h3);
        stream_ready_i = 1'b1;
        #1;
        check("nack_full_deq_yumi", 32'(stream_yumi_o), 32'h0);
        tick();
        check("nack_space_yumi", 32'(stream_yumi_o), 32'h1);
        stream_v_i = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
